systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_feeder_skew_select.sv | 34 +++
 rtl/systolic_feeder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and FSM state type for the systolic feeder
// Purpose: default array dimension/element width, run-length constants and the
//          feeder FSM state encoding, imported by every feeder file.
// Ports:   none (package).
package systolic_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int FEED_CYCLES = 2*DEF_N - 1;
  localparam int CS_CYCLES   = 3*DEF_N - 2;
  // Cycle counter width; must hold CS_CYCLES.
  localparam int T_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DONE
  } feed_state_t;

endpackage

// File: rtl/systolic_feeder_skew_select.sv
// rtl/systolic_feeder_skew_select.sv - skew tap for one array lane
// Purpose: picks element (t - LANE) of a row/column vector, or 0 when that
//          index falls outside 0..N-1 or the lane is disabled.
// Ports:   i_t    - feed cycle index t
//          i_en   - lane enable (compute enable)
//          i_vec  - N elements, element k at [k*WIDTH +: WIDTH]
//          o_elem - selected element or 0
module skew_select
  import systolic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int LANE  = 0
) (
  input  logic [T_W-1:0]     i_t,
  input  logic               i_en,
  input  logic [N*WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0]   o_elem
);

  logic [T_W:0] w_k;

  always_comb begin
    // One extra bit so t < LANE wraps to a value no element index can match.
    w_k    = {1'b0, i_t} - (T_W+1)'(LANE);
    o_elem = '0;
    for (int k = 0; k < N; k++) begin
      if (i_en && (w_k == (T_W+1)'(k))) begin
        o_elem = i_vec[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skewed operand feeder for a 4x4 systolic array
// Purpose: stores matrix A by row and B by column, then on start streams them
//          diagonally skewed onto the west/north buses for 10 compute cycles.
// Config:  FEEDER_DBLBUF_EN - two bank sets swapped on start; loads always
//          target the shadow set and are accepted while busy.
// Ports:   clk, rst_n (async active-low)
//          load_valid/load_ready/load_sel/load_idx/load_data - row/column write
//          start - begin a feed; busy, done (1-cycle pulse), cs - compute enable
//          west_data - array rows 0..3; north_data - array columns 0..3
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic               load_sel,
  input  logic [1:0]         load_idx,
  input  logic [N*WIDTH-1:0] load_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               cs,
  output logic [N*WIDTH-1:0] west_data,
  output logic [N*WIDTH-1:0] north_data
);

  feed_state_t        r_state, w_state_nxt;
  logic [T_W-1:0]     r_t, w_t_nxt;
  logic               w_start, w_load, w_cs_nxt;
  logic               w_wr_set, w_rd_set;
  logic [N*WIDTH-1:0] r_a [2][N];
  logic [N*WIDTH-1:0] r_b [2][N];
  logic [WIDTH-1:0]   w_west_e [N];
  logic [WIDTH-1:0]   w_north_e [N];
  logic [N*WIDTH-1:0] w_west, w_north;
  logic               r_busy, r_done, r_cs, r_load_ready;
  logic [N*WIDTH-1:0] r_west, r_north;

  assign w_start = (r_state == IDLE) && start;
  assign w_load  = load_valid && r_load_ready;

`ifdef FEEDER_DBLBUF_EN
  logic r_act, w_act_nxt;
  assign w_act_nxt = w_start ? ~r_act : r_act;
  assign w_rd_set  = w_act_nxt;
  assign w_wr_set  = ~w_act_nxt;
`else
  // Set 0 takes loads; set 1 is a snapshot taken on start so a load landing
  // on the start edge (or any later edge) cannot disturb the running feed.
  // The start edge itself reads set 0 directly, before the write lands.
  assign w_rd_set = w_start ? 1'b0 : 1'b1;
  assign w_wr_set = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = FEED;
          w_t_nxt     = '0;
        end
      end
      FEED: begin
        w_t_nxt = r_t + T_W'(1);
        if (r_t == T_W'(FEED_CYCLES - 1)) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        w_t_nxt = r_t + T_W'(1);
        if (r_t == T_W'(CS_CYCLES - 1)) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_t_nxt     = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_t_nxt     = '0;
      end
    endcase
    w_cs_nxt = (w_state_nxt == FEED) || (w_state_nxt == FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        for (int r = 0; r < N; r++) begin
          r_a[s][r] <= '0;
          r_b[s][r] <= '0;
        end
      end
`ifdef FEEDER_DBLBUF_EN
      r_act <= 1'b0;
`endif
    end else begin
`ifdef FEEDER_DBLBUF_EN
      r_act <= w_act_nxt;
`else
      if (w_start) begin
        for (int r = 0; r < N; r++) begin
          r_a[1][r] <= r_a[0][r];
          r_b[1][r] <= r_b[0][r];
        end
      end
`endif
      if (w_load) begin
        if (!load_sel) r_a[w_wr_set][load_idx] <= load_data;
        else           r_b[w_wr_set][load_idx] <= load_data;
      end
    end
  end

  // Outputs for cycle t are computed from the next-state values so they are
  // registered and visible in the cycle that follows the edge.
  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_select #(.WIDTH(WIDTH), .N(N), .LANE(g)) u_west (
      .i_t    (w_t_nxt),
      .i_en   (w_cs_nxt),
      .i_vec  (r_a[w_rd_set][g]),
      .o_elem (w_west_e[g])
    );
    skew_select #(.WIDTH(WIDTH), .N(N), .LANE(g)) u_north (
      .i_t    (w_t_nxt),
      .i_en   (w_cs_nxt),
      .i_vec  (r_b[w_rd_set][g]),
      .o_elem (w_north_e[g])
    );
  end

  always_comb begin
    w_west  = '0;
    w_north = '0;
    for (int k = 0; k < N; k++) begin
      w_west[k*WIDTH +: WIDTH]  = w_west_e[k];
      w_north[k*WIDTH +: WIDTH] = w_north_e[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cs         <= 1'b0;
      r_west       <= '0;
      r_north      <= '0;
      r_load_ready <= 1'b1;
    end else begin
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
      r_cs    <= w_cs_nxt;
      r_west  <= w_west;
      r_north <= w_north;
`ifdef FEEDER_DBLBUF_EN
      r_load_ready <= 1'b1;
`else
      r_load_ready <= (w_state_nxt == IDLE);
`endif
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign cs         = r_cs;
  assign west_data  = r_west;
  assign north_data = r_north;
  assign load_ready = r_load_ready;

endmodule
